// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
//   arb_state_e  : arbiter FSM encoding
//   FULL_BYTE_EN : byte-enable pattern used for instruction fetches
//   cnt_width()  : width needed for a counter that must reach max_val
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_e;

  localparam logic [3:0] FULL_BYTE_EN = 4'b1111;

  // Width of a counter that counts 0..max_val inclusive (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all arbiter-facing signals: fetch port, data port, pipeline
// stall requests, the single-ported memory bus and the error flag.
//   slave  : the arbiter's view
//   master : the surrounding pipeline/memory view
//
// Handshake: a requester raises x_req_i with stable address/data and holds it
// until the one-cycle x_valid_o pulse; mem_req_o is held until mem_ack_i,
// whose cycle also carries mem_rdata_i.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [DATA_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_valid_o;
  logic                  d_req_i;
  logic                  d_we_i;
  logic [DATA_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [3:0]            d_byte_en_i;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_valid_o;
  logic                  stall_f_o;
  logic                  stall_m_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [3:0]            mem_byte_en_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  err_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           d_byte_en_i, mem_ack_i, mem_rdata_i,
    output if_rdata_o, if_valid_o, d_rdata_o, d_valid_o, stall_f_o,
           stall_m_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_byte_en_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           d_byte_en_i, mem_ack_i, mem_rdata_i,
    input  if_rdata_o, if_valid_o, d_rdata_o, d_valid_o, stall_f_o,
           stall_m_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_byte_en_o, err_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch
// (IF) and load/store (MEM) stages. Data wins ties unless it has already won
// FAIR_LIMIT consecutive grants while a fetch waited. Each access runs
// IDLE -> BUSY_x -> RESP_x; BUSY is bounded by TIMEOUT cycles, after which
// the access completes with zero data and err_o latches until reset.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : mem_port_arbiter_if.slave (requesters, stalls, memory, err)
//   state_dbg : current FSM state for observation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output arb_state_e        state_dbg
);

  localparam int BUSY_W   = cnt_width(TIMEOUT);
  localparam int STREAK_W = cnt_width(FAIR_LIMIT);
  localparam logic [BUSY_W-1:0]   BUSY_MAX   = BUSY_W'(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIR_LIMIT);

  arb_state_e            state, state_next;
  logic [BUSY_W-1:0]     busy_cnt;
  logic [STREAK_W-1:0]   streak_cnt;
  logic                  grant_i, grant_d;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] load_data;

  assign timeout   = (busy_cnt == BUSY_MAX);
  // Stores complete with zero read data regardless of what the memory drives.
  assign load_data = bus.mem_we_o ? '0 : bus.mem_rdata_i;

  assign bus.if_valid_o = (state == RESP_I);
  assign bus.d_valid_o  = (state == RESP_D);
  assign bus.stall_f_o  = bus.if_req_i & ~bus.if_valid_o;
  assign bus.stall_m_o  = bus.d_req_i & ~bus.d_valid_o;
  assign state_dbg      = state;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // A saturated streak hands a tie to the waiting fetch.
        if (bus.d_req_i && !(bus.if_req_i && streak_cnt == STREAK_MAX)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (bus.if_req_i) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I:  if (bus.mem_ack_i || timeout) state_next = RESP_I;
      BUSY_D:  if (bus.mem_ack_i || timeout) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      busy_cnt          <= '0;
      streak_cnt        <= '0;
      bus.mem_req_o     <= 1'b0;
      bus.mem_we_o      <= 1'b0;
      bus.mem_addr_o    <= '0;
      bus.mem_wdata_o   <= '0;
      bus.mem_byte_en_o <= '0;
      bus.if_rdata_o    <= '0;
      bus.d_rdata_o     <= '0;
      bus.err_o         <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (!bus.if_req_i || grant_i) begin
            streak_cnt <= '0;
          end else if (grant_d && streak_cnt != STREAK_MAX) begin
            streak_cnt <= streak_cnt + STREAK_W'(1);
          end
          if (grant_d) begin
            busy_cnt          <= '0;
            bus.mem_req_o     <= 1'b1;
            bus.mem_we_o      <= bus.d_we_i;
            bus.mem_addr_o    <= bus.d_addr_i;
            bus.mem_wdata_o   <= bus.d_wdata_i;
            bus.mem_byte_en_o <= bus.d_byte_en_i;
          end else if (grant_i) begin
            busy_cnt          <= '0;
            bus.mem_req_o     <= 1'b1;
            bus.mem_we_o      <= 1'b0;
            bus.mem_addr_o    <= bus.if_addr_i;
            bus.mem_wdata_o   <= '0;
            bus.mem_byte_en_o <= FULL_BYTE_EN;
          end
        end
        BUSY_I, BUSY_D: begin
          busy_cnt <= busy_cnt + BUSY_W'(1);
          // An ack in the timeout cycle still delivers real data.
          if (bus.mem_ack_i) begin
            bus.mem_req_o <= 1'b0;
            if (state == BUSY_I) bus.if_rdata_o <= load_data;
            else                 bus.d_rdata_o  <= load_data;
          end else if (timeout) begin
            bus.mem_req_o <= 1'b0;
            bus.err_o     <= 1'b1;
            if (state == BUSY_I) bus.if_rdata_o <= '0;
            else                 bus.d_rdata_o  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
